// File: rtl/mtr_drv_nch.sv
// mtr_drv_nch: multi-channel H-bridge PWM driver with slew limiting,
// dead-band insertion, dynamic braking and drive enable.
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   en           : drive enable; low forces every bridge output off
//   brake[NCH]   : per-channel dynamic brake (both sides on after dead-band)
//   spd[NCH*W]   : packed signed target speeds, channel i at [i*W +: W]
//   spd_vld      : latch all targets this cycle
//   pwm1/pwm2    : per-channel low-side / high-side sense PWM (registered)
//   prd_sync     : one-cycle pulse at the start of each PWM period
module mtr_drv_nch #(
  parameter int unsigned W    = 11,
  parameter int unsigned NCH  = 2,
  parameter int unsigned DB   = 4,
  parameter int unsigned SLEW = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [NCH-1:0]   brake,
  input  logic [NCH*W-1:0] spd,
  input  logic             spd_vld,
  output logic [NCH-1:0]   pwm1,
  output logic [NCH-1:0]   pwm2,
  output logic             prd_sync
);

  localparam int unsigned DBW = (DB > 0) ? $clog2(DB + 1) : 1;
  localparam logic [DBW-1:0] DB_V = DBW'(DB);
  // Slew step held in W+2 bits; anything at or above the largest |diff| never limits.
  localparam logic [W+1:0] SLEW_V = (64'(SLEW) >= (64'(1) << (W + 1))) ?
                                    {1'b0, {(W+1){1'b1}}} : (W+2)'(SLEW);
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  // Per-channel bridge mode
  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_RUN = 2'd1;
  localparam logic [1:0] MODE_BRK = 2'd2;

  logic [W-1:0]   cnt_q, cnt_d;
  logic           prd_sync_q, prd_sync_d;
  logic           prd_end;
  logic [W-1:0]   tgt_q [NCH];
  logic [W-1:0]   tgt_d [NCH];
  logic [W-1:0]   app_q [NCH];
  logic [W-1:0]   app_d [NCH];
  logic [W-1:0]   duty  [NCH];
  logic [W-1:0]   stepped [NCH];
  logic [W:0]     diff  [NCH];
  logic [W:0]     mag   [NCH];
  logic [DBW-1:0] dbc_q [NCH];
  logic [DBW-1:0] dbc_d [NCH];
  logic [1:0]     mode_q [NCH];
  logic [1:0]     mode_d [NCH];
  logic [NCH-1:0] raw_q, raw_d;
  logic [NCH-1:0] pwm1_q, pwm1_d;
  logic [NCH-1:0] pwm2_q, pwm2_d;

  // Next-state logic for the shared counter and every channel
  always_comb begin
    cnt_d      = cnt_q + W'(1);
    prd_end    = (cnt_q == {W{1'b1}});
    prd_sync_d = prd_end;
    pwm1_d     = '0;
    pwm2_d     = '0;
    raw_d      = '0;
    for (int i = 0; i < NCH; i++) begin
      tgt_d[i] = spd_vld ? spd[i*W +: W] : tgt_q[i];

      // Signed difference in W+1 bits; stepping toward tgt never overshoots it.
      diff[i]    = {tgt_q[i][W-1], tgt_q[i]} - {app_q[i][W-1], app_q[i]};
      mag[i]     = diff[i][W] ? -diff[i] : diff[i];
      stepped[i] = W'({{2{app_q[i][W-1]}}, app_q[i]} + (diff[i][W] ? -SLEW_V : SLEW_V));

      if (!en)          mode_d[i] = MODE_OFF;
      else if (brake[i]) mode_d[i] = MODE_BRK;
      else              mode_d[i] = MODE_RUN;

      // Applied speed: cleared when not running, otherwise moves only at period end.
      app_d[i] = app_q[i];
      if (mode_d[i] != MODE_RUN) begin
        app_d[i] = '0;
      end else if (prd_end) begin
        if ((SLEW == 0) || ({1'b0, mag[i]} <= SLEW_V)) app_d[i] = tgt_q[i];
        else                                          app_d[i] = stepped[i];
      end

      // Offset-binary duty: adding half-scale just flips the sign bit.
      duty[i]  = app_q[i] + HALF;
      raw_d[i] = (cnt_q < duty[i]);

      // Raw edges only matter while running; a mode change always restarts the gap.
      if ((mode_d[i] != mode_q[i]) ||
          ((mode_d[i] == MODE_RUN) && (raw_d[i] != raw_q[i]))) begin
        dbc_d[i] = DB_V;
      end else if (dbc_q[i] != '0) begin
        dbc_d[i] = dbc_q[i] - DBW'(1);
      end else begin
        dbc_d[i] = '0;
      end

      if (en && (mode_q[i] != MODE_OFF) && (dbc_q[i] == '0)) begin
        if (mode_q[i] == MODE_BRK) begin
          pwm1_d[i] = 1'b1;
          pwm2_d[i] = 1'b1;
        end else begin
          pwm1_d[i] = ~raw_q[i];
          pwm2_d[i] = raw_q[i];
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      prd_sync_q <= 1'b0;
      raw_q      <= '0;
      pwm1_q     <= '0;
      pwm2_q     <= '0;
      for (int i = 0; i < NCH; i++) begin
        tgt_q[i]  <= '0;
        app_q[i]  <= '0;
        dbc_q[i]  <= '0;
        mode_q[i] <= MODE_OFF;
      end
    end else begin
      cnt_q      <= cnt_d;
      prd_sync_q <= prd_sync_d;
      raw_q      <= raw_d;
      pwm1_q     <= pwm1_d;
      pwm2_q     <= pwm2_d;
      for (int i = 0; i < NCH; i++) begin
        tgt_q[i]  <= tgt_d[i];
        app_q[i]  <= app_d[i];
        dbc_q[i]  <= dbc_d[i];
        mode_q[i] <= mode_d[i];
      end
    end
  end

  assign pwm1     = pwm1_q;
  assign pwm2     = pwm2_q;
  assign prd_sync = prd_sync_q;

endmodule

// File: tb/tb_mtr_drv_nch.sv
// tb_mtr_drv_nch: directed + randomized bench for mtr_drv_nch.
// Two instances share stimulus: u_dut_a (SLEW=64) and u_dut_b (SLEW=0).
// A cycle-level reference model tracks drive symbols per channel and blanks
// any output whose symbol changed within the last DB cycles.
module tb_mtr_drv_nch;

  localparam int W    = 11;
  localparam int NCH  = 2;
  localparam int DB   = 4;
  localparam int PER  = 2048;
  localparam int HALF = 1024;

  localparam int S_OFF = 0;
  localparam int S_BRK = 1;
  localparam int S_LO  = 2;
  localparam int S_HI  = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [NCH-1:0]   brake = '0;
  logic [NCH*W-1:0] spd = '0;
  logic             spd_vld = 1'b0;
  logic [NCH-1:0]   pwm1_a, pwm2_a, pwm1_b, pwm2_b;
  logic             prd_a, prd_b;

  int n_chk = 0;
  int n_pass = 0;

  int m_cnt;
  int m_tgt  [NCH];
  int m_app  [2][NCH];
  int m_hist [2][NCH][DB+1];
  int c_p1   [2][NCH];
  int c_p2   [2][NCH];
  int c_lo   [2][NCH];

  always #5 clk = ~clk;

  mtr_drv_nch #(.W(W), .NCH(NCH), .DB(DB), .SLEW(64)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .brake(brake), .spd(spd), .spd_vld(spd_vld),
    .pwm1(pwm1_a), .pwm2(pwm2_a), .prd_sync(prd_a)
  );

  mtr_drv_nch #(.W(W), .NCH(NCH), .DB(DB), .SLEW(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .brake(brake), .spd(spd), .spd_vld(spd_vld),
    .pwm1(pwm1_b), .pwm2(pwm2_b), .prd_sync(prd_b)
  );

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
  endtask

  function automatic int slew_of(input int n);
    return (n == 0) ? 64 : 0;
  endfunction

  function automatic logic [NCH*W-1:0] pack2(input int s0, input int s1);
    logic [NCH*W-1:0] r;
    r = '0;
    r[0 +: W] = W'(s0);
    r[W +: W] = W'(s1);
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    for (int c = 0; c < NCH; c++) begin
      m_tgt[c] = 0;
      for (int n = 0; n < 2; n++) begin
        m_app[n][c] = 0;
        for (int m = 0; m <= DB; m++) m_hist[n][c][m] = S_OFF;
      end
    end
  endtask

  task automatic clr_counts();
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < NCH; c++) begin
        c_p1[n][c] = 0;
        c_p2[n][c] = 0;
        c_lo[n][c] = 0;
      end
  endtask

  // One clock: predict outputs from the model, advance it, then compare.
  task automatic tick();
    logic [NCH-1:0]   x1 [2];
    logic [NCH-1:0]   x2 [2];
    logic             xp;
    logic signed [W-1:0] v;
    int  cur, sym, d, sl;
    bit  dead;
    logic o1, o2;
    for (int n = 0; n < 2; n++) begin
      x1[n] = '0;
      x2[n] = '0;
      for (int c = 0; c < NCH; c++) begin
        cur  = m_hist[n][c][0];
        dead = 1'b0;
        for (int m = 0; m < DB; m++)
          if (m_hist[n][c][m] != m_hist[n][c][m+1]) dead = 1'b1;
        if (en && cur != S_OFF && !dead) begin
          if (cur == S_BRK) begin
            x1[n][c] = 1'b1;
            x2[n][c] = 1'b1;
          end else if (cur == S_HI) x2[n][c] = 1'b1;
          else                      x1[n][c] = 1'b1;
        end
        if (!en)          sym = S_OFF;
        else if (brake[c]) sym = S_BRK;
        else              sym = (m_cnt < m_app[n][c] + HALF) ? S_HI : S_LO;
        if (!en || brake[c]) begin
          m_app[n][c] = 0;
        end else if (m_cnt == PER - 1) begin
          d  = m_tgt[c] - m_app[n][c];
          sl = slew_of(n);
          if (sl == 0 || (d <= sl && d >= -sl)) m_app[n][c] = m_tgt[c];
          else m_app[n][c] = m_app[n][c] + ((d > 0) ? sl : -sl);
        end
        for (int m = DB; m > 0; m--) m_hist[n][c][m] = m_hist[n][c][m-1];
        m_hist[n][c][0] = sym;
      end
    end
    xp = (m_cnt == PER - 1);
    if (spd_vld)
      for (int c = 0; c < NCH; c++) begin
        v = spd[c*W +: W];
        m_tgt[c] = int'(v);
      end
    m_cnt = (m_cnt + 1) % PER;

    @(posedge clk);
    #1;
    chk("pwm1_a", 32'(pwm1_a), 32'(x1[0]));
    chk("pwm2_a", 32'(pwm2_a), 32'(x2[0]));
    chk("pwm1_b", 32'(pwm1_b), 32'(x1[1]));
    chk("pwm2_b", 32'(pwm2_b), 32'(x2[1]));
    chk("prd_a", 32'(prd_a), 32'(xp));
    chk("prd_b", 32'(prd_b), 32'(xp));
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < NCH; c++) begin
        o1 = (n == 0) ? pwm1_a[c] : pwm1_b[c];
        o2 = (n == 0) ? pwm2_a[c] : pwm2_b[c];
        if (o1) c_p1[n][c]++;
        if (o2) c_p2[n][c]++;
        if (!o1 && !o2) c_lo[n][c]++;
      end
  endtask

  task automatic run_to_sync(input string tag);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (prd_a !== 1'b1 && k < PER + 50);
    chk(tag, 32'(prd_a), 32'd1);
  endtask

  task automatic measure();
    clr_counts();
    repeat (PER) tick();
  endtask

  initial begin
    int k;
    model_reset();
    clr_counts();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pwm1_a", 32'(pwm1_a), 32'd0);
    chk("rst_pwm2_a", 32'(pwm2_a), 32'd0);
    chk("rst_prd_a",  32'(prd_a),  32'd0);
    chk("rst_pwm1_b", 32'(pwm1_b), 32'd0);
    chk("rst_pwm2_b", 32'(pwm2_b), 32'd0);

    // 50% duty with dead-band after reset, zero targets
    en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_to_sync("sync_first");
    measure();
    for (int n = 0; n < 2; n++)
      for (int c = 0; c < NCH; c++) begin
        chk("half_p2", 32'(c_p2[n][c]), 32'd1020);
        chk("half_p1", 32'(c_p1[n][c]), 32'd1020);
        chk("half_lo", 32'(c_lo[n][c]), 32'd8);
      end

    // Slew ramp ch0 to 512; ch1 stays at zero
    repeat (700) tick();
    spd = pack2(512, 0);
    spd_vld = 1'b1;
    tick();
    spd_vld = 1'b0;
    run_to_sync("sync_ramp");
    for (int p = 1; p <= 9; p++) begin
      measure();
      chk("ramp_a0_p2", 32'(c_p2[0][0]), 32'(1024 + 64 * ((p < 8) ? p : 8) - 4));
      chk("ramp_a1_p2", 32'(c_p2[0][1]), 32'd1020);
      if (p == 1) chk("step_b0_p2", 32'(c_p2[1][0]), 32'd1532);
    end
    chk("ramp_a0_p1", 32'(c_p1[0][0]), 32'd508);

    // Full reverse on unlimited-slew instance: constant low side, no gaps
    repeat (100) tick();
    spd = pack2(512, -1024);
    spd_vld = 1'b1;
    tick();
    spd_vld = 1'b0;
    run_to_sync("sync_rev");
    measure();
    chk("rev_b1_p1", 32'(c_p1[1][1]), 32'd2048);
    chk("rev_b1_p2", 32'(c_p2[1][1]), 32'd0);
    chk("rev_b1_lo", 32'(c_lo[1][1]), 32'd0);

    // Brake pulse on ch0 mid-period
    repeat (300) tick();
    brake = 2'b01;
    tick();
    repeat (4) begin
      tick();
      chk("brk_in_gap", 32'({pwm1_a[0], pwm2_a[0]}), 32'd0);
    end
    repeat (10) begin
      tick();
      chk("brk_on", 32'({pwm1_a[0], pwm2_a[0]}), 32'd3);
    end
    brake = 2'b00;
    tick();
    repeat (4) begin
      tick();
      chk("brk_out_gap", 32'({pwm1_a[0], pwm2_a[0]}), 32'd0);
    end
    tick();
    chk("brk_resume", 32'({pwm1_a[0], pwm2_a[0]}), 32'd1);

    // Enable drop and restore: ramp restarts from zero
    repeat (200) tick();
    en = 1'b0;
    tick();
    chk("en_off_pwm1_a", 32'(pwm1_a), 32'd0);
    chk("en_off_pwm2_a", 32'(pwm2_a), 32'd0);
    chk("en_off_pwm1_b", 32'(pwm1_b), 32'd0);
    chk("en_off_pwm2_b", 32'(pwm2_b), 32'd0);
    repeat (50) tick();
    en = 1'b1;
    run_to_sync("sync_en");
    measure();
    chk("en_a0_p2", 32'(c_p2[0][0]), 32'd1084);
    chk("en_a1_p2", 32'(c_p2[0][1]), 32'd956);
    chk("en_a1_p1", 32'(c_p1[0][1]), 32'd1084);

    // Randomized targets, brakes and enable glitches against the model
    repeat (4 * PER) begin
      spd_vld = ($urandom_range(0, 63) == 0);
      if (spd_vld) spd = (NCH*W)'($urandom);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 299) == 0) brake[c] = ~brake[c];
      en = ($urandom_range(0, 799) != 0);
      tick();
    end
    brake = '0;
    en = 1'b1;
    spd_vld = 1'b0;

    // Asynchronous reset mid-period with a nonzero applied speed
    spd = pack2(300, 0);
    spd_vld = 1'b1;
    tick();
    spd_vld = 1'b0;
    run_to_sync("sync_pre_rst");
    repeat (500) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm1_a", 32'(pwm1_a), 32'd0);
    chk("arst_pwm2_a", 32'(pwm2_a), 32'd0);
    chk("arst_pwm1_b", 32'(pwm1_b), 32'd0);
    chk("arst_pwm2_b", 32'(pwm2_b), 32'd0);
    chk("arst_prd_a",  32'(prd_a),  32'd0);
    model_reset();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (prd_a !== 1'b1 && k < PER + 50);
    chk("arst_cnt_restart", 32'(k), 32'(PER));
    measure();
    chk("arst_a0_p2", 32'(c_p2[0][0]), 32'd1020);
    chk("arst_b0_p2", 32'(c_p2[1][0]), 32'd1020);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mtr_drv_nch.md
MTR_DRV_NCH -- requirements
Module: mtr_drv_nch

Interface
REQ-001 SHALL have parameter W, default 11: signed speed width; the PWM period is 2^W clk cycles.
REQ-002 SHALL have parameter NCH, default 2: number of motor channels.
REQ-003 SHALL have parameter DB, default 4: dead-band length in clk cycles; 0 disables dead-band.
REQ-004 SHALL have parameter SLEW, default 64: maximum change of applied speed per PWM period; 0 means no limit.
REQ-005 SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port en, input, 1 bit: drive enable.
REQ-008 SHALL have port brake, input, NCH bits: per-channel dynamic brake request.
REQ-009 SHALL have port spd, input, NCH*W bits: packed signed target speeds; channel i occupies bits [i*W +: W].
REQ-010 SHALL have port spd_vld, input, 1 bit: latch all targets this cycle.
REQ-011 SHALL have port pwm1, output, NCH bits: low-side-sense PWM per channel.
REQ-012 SHALL have port pwm2, output, NCH bits: high-side-sense PWM per channel.
REQ-013 SHALL have port prd_sync, output, 1 bit: one-cycle pulse at period start.

Function
REQ-014 SHALL keep one shared free-running W-bit counter cnt.
  - cnt increments every clk.
  - cnt wraps from 2^W-1 to 0.
  - prd_sync is registered high in the cycle after cnt==2^W-1.
REQ-015 SHALL, per channel, load target register tgt from spd when spd_vld=1; otherwise tgt holds.
REQ-016 SHALL, per channel, update applied speed app only in the cycle where cnt==2^W-1, so a new duty starts exactly at cnt==0:
  - diff = tgt - app, computed in W+1 bits signed.
  - If SLEW==0 or |diff|<=SLEW: app = tgt.
  - Else: app = app + SLEW*sign(diff).
REQ-017 SHALL compute duty = app + 2^(W-1) as unsigned W bits.
  - -2^(W-1) maps to 0; 0 maps to 2^(W-1); 2^(W-1)-1 maps to 2^W-1.
  - No saturation is needed.
REQ-018 SHALL register raw = (cnt < duty) each cycle, per channel.
REQ-019 SHALL, in normal mode, drive outputs as follows:
  - pwm2 = raw and not dead; pwm1 = not raw and not dead.
  - pwm1 and pwm2 are never both 1 in normal mode.
REQ-020 SHALL implement a per-channel dead-band counter dbc:
  - Load DB on any change of raw or of the brake-mode state.
  - Decrement to 0 otherwise.
  - dead = (dbc != 0).
  - A change during an active dead-band reloads DB.
REQ-021 SHALL, with constant raw (duty 0 or a constant level), insert no dead-band gaps.
REQ-022 SHALL, when brake[i]=1 and en=1:
  - Clear app[i] to 0 immediately.
  - Hold app[i] at 0 while braking.
  - After the dead-band, drive pwm1[i] = pwm2[i] = 1.
REQ-023 SHALL, on brake release:
  - Pass through DB all-low cycles.
  - Resume normal mode with app ramping from 0 per REQ-016.
REQ-024 SHALL, when en=0:
  - Force all pwm1/pwm2 to 0 on the next clk.
  - Clear all app to 0.
  - Keep tgt and cnt running.
  - Priority: en=0 over brake over normal.
REQ-025 SHALL register all outputs.
  - pwm changes lag raw by 1 clk.
  - There is no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously clear cnt, tgt, app, raw, dbc, pwm1, pwm2 and prd_sync to 0.
REQ-027 SHALL, in the first period after reset release with en=1 and no new target, output 50% duty (app=0) with dead-band applied.
REQ-028 SHALL, on reset asserted mid-period, drive all outputs low within the same cycle (asynchronously).

Verification
REQ-029 SHALL cover (W=11, NCH=2, DB=4, SLEW=64): en=1, spd=0 both channels -> per 2048-cycle period, pwm2 high 1020 cycles, pwm1 high 1020 cycles, 4+4 all-low cycles.
REQ-030 SHALL cover: spd ch0 = 512 from app=0 -> app steps 64, 128, ..., 512 over 8 consecutive periods; duty reaches 1536; ch1 unaffected.
REQ-031 SHALL cover: spd ch1 = -1024 with SLEW=0 -> next period pwm1[1] constantly 1 and pwm2[1] constantly 0, with no dead-band gaps.
REQ-032 SHALL cover: brake[0] pulsed high mid-period -> 4 all-low cycles, then pwm1[0]=pwm2[0]=1; on release, 4 all-low cycles, then 50% duty.
REQ-033 SHALL cover: en dropped mid-period -> all outputs 0 next clk; en restored -> ramp restarts from app=0.
REQ-034 SHALL cover: rst_n asserted mid-period with app=300 -> outputs 0 immediately; after release, cnt restarts at 0 and app=0.
